// File: rtl/cpu16_pkg.sv
// Shared constants for the 16-bit processor: field widths, the HALT encoding,
// loader FSM state codes and the field-packing helper.
package cpu16_pkg;

  localparam int OP_W    = 4;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

  localparam logic [1:0] LDR_IDLE  = 2'd0;
  localparam logic [1:0] LDR_LOAD  = 2'd1;
  localparam logic [1:0] LDR_DRAIN = 2'd2;

  // Inverse of the instructiondecoder split: op lands in the top nibble.
  function automatic logic [INSTR_W-1:0] pack_instr(
    input logic [OP_W-1:0] op,
    input logic [OP_W-1:0] q0,
    input logic [OP_W-1:0] q1,
    input logic [OP_W-1:0] dest
  );
    return {op, q0, q1, dest};
  endfunction

endpackage

// File: rtl/iencoder_loader_chk.sv
// Protocol checks on the instruction-memory write port and the session pulse.
module iencoder_loader_chk #(
  parameter int ADDR_W = 8
) (
  input logic              clk,
  input logic              rst,
  input logic              mem_we,
  input logic              mem_ready,
  input logic [ADDR_W-1:0] mem_addr,
  input logic [15:0]       mem_wdata,
  input logic              done,
  input logic              busy
);

  stall_hold: assert property (@(posedge clk) disable iff (rst)
    (mem_we && !mem_ready) |=> (mem_we && $stable(mem_addr) && $stable(mem_wdata)));

  done_single: assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

  done_idle: assert property (@(posedge clk) disable iff (rst)
    done |-> !busy);

endmodule

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO built from a head and a tail register so that the
// read side (out_valid/out_data) comes straight from flops.
module sync_fifo2
  import cpu16_pkg::*;
#(
  parameter int W = INSTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   level
);

  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic         head_v_r;
  logic         tail_v_r;
  logic         push_s;
  logic         pop_s;

  // The tail is only ever occupied while the head is, so full == tail valid.
  assign in_ready  = !tail_v_r;
  assign push_s    = in_valid && !tail_v_r;
  assign pop_s     = head_v_r && out_ready;
  assign out_valid = head_v_r;
  assign out_data  = head_r;

  // Head/tail storage update; a simultaneous push and pop at one entry refills the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r   <= {W{1'b0}};
      tail_r   <= {W{1'b0}};
      head_v_r <= 1'b0;
      tail_v_r <= 1'b0;
    end else if (pop_s) begin
      if (tail_v_r) begin
        head_r   <= tail_r;
        tail_v_r <= 1'b0;
      end else if (push_s) begin
        head_r   <= in_data;
      end else begin
        head_v_r <= 1'b0;
      end
    end else if (push_s) begin
      if (head_v_r) begin
        tail_r   <= in_data;
        tail_v_r <= 1'b1;
      end else begin
        head_r   <= in_data;
        head_v_r <= 1'b1;
      end
    end
  end

  // Occupancy derived from the two valid flags.
  always_comb begin
    level = 2'd0;
    if (tail_v_r) begin
      level = 2'd2;
    end else if (head_v_r) begin
      level = 2'd1;
    end else begin
      level = 2'd0;
    end
  end

endmodule

// File: rtl/iencoder_loader.sv
// Instruction encoder and program loader: packs field tuples into 16-bit words
// and writes them to consecutive instruction-memory addresses.
module iencoder_loader
  import cpu16_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [OP_W-1:0]   q0,
  input  logic [OP_W-1:0]   q1,
  input  logic [OP_W-1:0]   dest,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  loaded
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   accepted_r;
  logic [CNT_W-1:0]   loaded_r;
  logic               last_acc_r;
  logic               busy_r;
  logic               done_r;

  logic [INSTR_W-1:0] word_s;
  logic [INSTR_W-1:0] head_s;
  logic               fifo_in_ready_s;
  logic               fifo_out_valid_s;
  logic [1:0]         level_s;
  logic               ready_s;
  logic               accept_s;
  logic               write_s;
  logic               last_s;

  assign word_s   = pack_instr(op, q0, q1, dest);
  assign ready_s  = (state_r == LDR_LOAD) && fifo_in_ready_s && !last_acc_r;
  assign accept_s = in_valid && ready_s;
  assign write_s  = fifo_out_valid_s && mem_ready;

  // A tuple is the last one if it is HALT or it brings the accepted count to a non-zero limit.
  always_comb begin
    last_s = 1'b0;
    if (word_s == HALT_WORD) begin
      last_s = 1'b1;
    end else if ((count_r != CNT_ZERO) && ((accepted_r + CNT_ONE) == count_r)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  sync_fifo2 #(.W(INSTR_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept_s),
    .in_ready  (fifo_in_ready_s),
    .in_data   (word_s),
    .out_valid (fifo_out_valid_s),
    .out_ready (mem_ready),
    .out_data  (head_s),
    .level     (level_s)
  );

  // Session FSM plus write-address and loaded-word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= LDR_IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      count_r    <= CNT_ZERO;
      accepted_r <= CNT_ZERO;
      loaded_r   <= CNT_ZERO;
      last_acc_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (write_s) begin
        addr_r   <= addr_r + ADDR_ONE;
        loaded_r <= loaded_r + CNT_ONE;
      end
      case (state_r)
        LDR_IDLE: begin
          if (start) begin
            state_r    <= LDR_LOAD;
            addr_r     <= base_addr;
            count_r    <= count;
            accepted_r <= CNT_ZERO;
            loaded_r   <= CNT_ZERO;
            last_acc_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        LDR_LOAD: begin
          if (accept_s) begin
            accepted_r <= accepted_r + CNT_ONE;
            if (last_s) begin
              last_acc_r <= 1'b1;
              state_r    <= LDR_DRAIN;
            end
          end
        end
        LDR_DRAIN: begin
          // Finishing needs the handshake on the only remaining entry.
          if (write_s && (level_s == 2'd1)) begin
            state_r <= LDR_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= LDR_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ready_s;
  assign mem_we    = fifo_out_valid_s;
  assign mem_addr  = addr_r;
  assign mem_wdata = head_s;
  assign busy      = busy_r;
  assign done      = done_r;
  assign loaded    = loaded_r;

  iencoder_loader_chk #(.ADDR_W(ADDR_W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .busy      (busy)
  );

endmodule
